// File: rtl/nn_mac_neuron_if.sv
// Stream, config and status bundle for the int8 MAC neuron.
interface nn_mac_neuron_if #(
   parameter int CFG_AW = 3
) ();
   logic              in_valid;
   logic [31:0]       in_data;
   logic              in_ready;
   logic              cfg_we;
   logic [CFG_AW-1:0] cfg_addr;
   logic [31:0]       cfg_data;
   logic              out_valid;
   logic [7:0]        out_data;
   logic              out_ready;
   logic              busy;

   modport master (
      output in_valid, in_data, cfg_we, cfg_addr, cfg_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, cfg_we, cfg_addr, cfg_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/nn_mac_neuron.sv
// Single int8 MAC neuron: accumulate, bias, shift, saturate, emit one byte.
// Define NN_RELU_EN for ReLU clamping (0..127) instead of signed saturation.
module nn_mac_neuron #(
   parameter int N_WORDS   = 4,
   parameter int ACC_W     = 24,
   parameter int OUT_SHIFT = 4,
   parameter int CFG_AW    = 3
) (
   input logic           wb_clk_i,
   input logic           wb_rst_i,
   nn_mac_neuron_if.slave bus
);
   typedef enum logic [1:0] {S_ACC, S_ACT, S_OUT} state_t;

   localparam logic [CFG_AW-1:0] LAST_IDX  = CFG_AW'(N_WORDS - 1);
   localparam logic [CFG_AW-1:0] BIAS_ADDR = CFG_AW'(N_WORDS);
   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(127);
`ifdef NN_RELU_EN
   localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(0);
`else
   localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-128);
`endif

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CFG_AW-1:0] idx_q, idx_d;
   logic [31:0]       w_q [N_WORDS];
   logic [ACC_W-1:0]  bias_q;
   logic              out_valid_q, out_valid_d;
   logic [7:0]        out_data_q, out_data_d;

   logic              accept;
   logic              busy;
   logic [31:0]       w_cur;
   logic [15:0]       prod [4];
   logic [17:0]       word_sum;
   logic signed [ACC_W-1:0] biased;
   logic signed [ACC_W-1:0] r;
   logic [7:0]        sat_byte;

   assign bus.in_ready  = (state_q == S_ACC) && !wb_rst_i;
   assign accept        = bus.in_valid && bus.in_ready;
   assign busy          = (state_q != S_ACC) || (idx_q != '0);
   assign bus.busy      = busy;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   always_comb begin
      w_cur = '0;
      for (int i = 0; i < N_WORDS; i++)
         if (idx_q == CFG_AW'(i))
            w_cur = w_q[i];
   end

   // Sign-extended 16-bit products keep only the low 16 bits, which hold the exact signed product.
   always_comb begin
      word_sum = '0;
      for (int k = 0; k < 4; k++) begin
         prod[k] = {{8{bus.in_data[8*k+7]}}, bus.in_data[8*k +: 8]} *
                   {{8{w_cur[8*k+7]}}, w_cur[8*k +: 8]};
         word_sum = word_sum + {{2{prod[k][15]}}, prod[k]};
      end
   end

   assign biased = signed'(acc_q + bias_q);
   assign r      = biased >>> OUT_SHIFT;

   always_comb begin
      sat_byte = r[7:0];
      if (r > MAX_V)
         sat_byte = MAX_V[7:0];
      else if (r < MIN_V)
         sat_byte = MIN_V[7:0];
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      unique case (state_q)
         S_ACC: begin
            if (accept) begin
               acc_d = acc_q + {{(ACC_W-18){word_sum[17]}}, word_sum};
               idx_d = idx_q + 1'b1;
               if (idx_q == LAST_IDX)
                  state_d = S_ACT;
            end
         end
         S_ACT: begin
            out_data_d  = sat_byte;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               idx_d       = '0;
               state_d     = S_ACC;
            end
         end
         default: state_d = S_ACC;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= S_ACC;
         acc_q       <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Coefficients only change between inferences so a result never mixes two weight sets.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < N_WORDS; i++)
            w_q[i] <= '0;
         bias_q <= '0;
      end else if (bus.cfg_we && !busy) begin
         for (int i = 0; i < N_WORDS; i++)
            if (bus.cfg_addr == CFG_AW'(i))
               w_q[i] <= bus.cfg_data;
         if (bus.cfg_addr == BIAS_ADDR)
            bias_q <= bus.cfg_data[ACC_W-1:0];
      end
   end
endmodule

// File: tb/tb_nn_mac_neuron.sv
// Randomized bench for nn_mac_neuron with an in-bench dot-product model.
module tb_nn_mac_neuron;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nn_mac_neuron_if #(.CFG_AW(3)) bus ();

   nn_mac_neuron #(
      .N_WORDS(N), .ACC_W(24), .OUT_SHIFT(4), .CFG_AW(3)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Upstream FIFO
   logic [31:0] fifo_q[$];
   int gap_pct = 0;
   int cyc = 0;
   int last_pop_cyc = 0;

   always @(negedge clk) begin
      bus.in_valid = (fifo_q.size() != 0) && ($urandom_range(0, 99) >= gap_pct);
      bus.in_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
   end

   always @(posedge clk) begin
      cyc++;
      if (!rst && bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
         void'(fifo_q.pop_front());
         last_pop_cyc = cyc;
      end
   end

   // Behavioural model
   logic [31:0] mw [N];
   int   mbias, macc, mcnt, msum;
   bit   mact, mov, mbusy;
   logic [7:0] mod;

   function automatic int dot(logic [31:0] a, logic [31:0] b);
      int s = 0;
      for (int k = 0; k < 4; k++)
         s += int'($signed(a[8*k +: 8])) * int'($signed(b[8*k +: 8]));
      return s;
   endfunction

   function automatic logic [7:0] sat(int v);
`ifdef NN_RELU_EN
      if (v < 0) return 8'h00;
`else
      if (v < -128) return 8'h80;
`endif
      if (v > 127) return 8'h7F;
      return v[7:0];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) mw[i] = 32'h0;
         mbias = 0; macc = 0; mcnt = 0;
         mact = 0; mov = 0; mod = 8'h00;
      end else begin
         mbusy = mact || mov || (mcnt != 0);
         if (!mact && !mov && bus.in_valid === 1'b1) begin
            macc += dot(bus.in_data, mw[mcnt]);
            mcnt++;
            if (mcnt == N) mact = 1;
         end else if (mact) begin
            msum = macc + mbias;
            msum = (msum <<< 8) >>> 8;
            mod  = sat(msum >>> 4);
            mov  = 1; mact = 0;
         end else if (mov && bus.out_ready === 1'b1) begin
            mov = 0; macc = 0; mcnt = 0;
         end
         if (bus.cfg_we === 1'b1 && !mbusy) begin
            if (bus.cfg_addr < 3'd4)
               mw[bus.cfg_addr] = bus.cfg_data;
            else if (bus.cfg_addr == 3'd4)
               mbias = int'({{8{bus.cfg_data[23]}}, bus.cfg_data[23:0]});
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      chk("in_ready", bus.in_ready, !rst && !mact && !mov);
      chk("out_valid", bus.out_valid, mov);
      chk("busy", bus.busy, mact || mov || (mcnt != 0));
      if (mov) chk("out_data", bus.out_data, mod);
   end

   task automatic cfg_wr(int a, logic [31:0] d);
      @(negedge clk);
      bus.cfg_we = 1'b1; bus.cfg_addr = 3'(a); bus.cfg_data = d;
      @(negedge clk);
      bus.cfg_we = 1'b0;
   endtask

   task automatic set_all(logic [31:0] w, logic [31:0] b);
      for (int i = 0; i < N; i++) cfg_wr(i, w);
      cfg_wr(4, b);
   endtask

   task automatic push_n(int n, logic [31:0] w);
      for (int i = 0; i < n; i++) fifo_q.push_back(w);
   endtask

   task automatic drain(string name);
      int n = 0;
      while (fifo_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         checks++; failures++;
         $display("FAIL %s fifo not drained actual=%0d required=0", name, fifo_q.size());
      end
      @(negedge clk);
   endtask

   task automatic wait_valid(string name, output int seen);
      int n = 0;
      while (bus.out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         checks++; failures++;
         $display("FAIL %s timeout out_valid actual=0 required=1", name);
      end
      seen = cyc;
   endtask

   task automatic accept();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic result(string name, logic [7:0] exp);
      int s;
      wait_valid(name, s);
      chk(name, bus.out_data, exp);
      accept();
   endtask

   initial begin
      int seen, sz;
      logic [7:0] d0;
      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_out_data", bus.out_data, 8'h00);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1'b1);

      set_all(32'h01010101, 32'h0);
      push_n(4, 32'h04040404);
      wait_valid("basic", seen);
      chk("basic_data", bus.out_data, 8'h04);
      chk("basic_latency", seen - last_pop_cyc, 1);
      accept();

      set_all(32'hFFFFFFFF, 32'h0);
      push_n(4, 32'h04040404);
`ifdef NN_RELU_EN
      result("sign", 8'h00);
`else
      result("sign", 8'hFC);
`endif

      set_all(32'h7F7F7F7F, 32'h0);
      push_n(4, 32'h7F7F7F7F);
      result("saturate", 8'h7F);

      set_all(32'h0, 32'h00000100);
      push_n(4, 32'h04040404);
      result("bias", 8'h10);

      set_all(32'h01010101, 32'h0);
      gap_pct = 50;
      push_n(4, 32'h04040404);
      result("gaps", 8'h04);
      gap_pct = 0;

      push_n(8, 32'h04040404);
      wait_valid("bp", seen);
      d0 = bus.out_data;
      sz = fifo_q.size();
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", bus.out_valid, 1'b1);
         chk("bp_data", bus.out_data, d0);
         chk("bp_in_ready", bus.in_ready, 1'b0);
      end
      chk("bp_fifo", fifo_q.size(), 4);
      chk("bp_first", d0, 8'h04);
      accept();
      result("bp_second", 8'h04);

      push_n(2, 32'h04040404);
      drain("guard");
      chk("guard_busy", bus.busy, 1'b1);
      cfg_wr(0, 32'h02020202);
      push_n(2, 32'h04040404);
      result("guard_drop", 8'h04);
      cfg_wr(0, 32'h02020202);
      push_n(4, 32'h04040404);
      result("guard_apply", 8'h05);

      set_all(32'h01010101, 32'h0);
      push_n(2, 32'h04040404);
      drain("reset");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_valid", bus.out_valid, 1'b0);
      push_n(4, 32'h04040404);
      result("post_reset", 8'h00);

      for (int it = 0; it < 20; it++) begin
         for (int i = 0; i < N; i++) cfg_wr(i, $urandom);
         cfg_wr(4, $urandom);
         cfg_wr($urandom_range(5, 7), $urandom);
         gap_pct = $urandom_range(0, 60);
         for (int j = 0; j < N; j++) fifo_q.push_back($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         cfg_wr($urandom_range(0, 4), $urandom);
         wait_valid("rand", seen);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         accept();
      end
      gap_pct = 0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
